// File: rtl/conv_mesh_pkg.sv
// conv_mesh_pkg: shared types and elaboration helpers for the convolutional mesh.
//   state_t      : sequencer state encoding (IDLE, COMPUTE, DRAIN)
//   cnt_width()  : width of a tap count able to hold 0..kmax
//   row_width()  : width of a row index for a mesh of 'rows' rows (minimum 1)
//   CONV_MESH_CHECK_ACC_W : generate-region check that the accumulator can
//                           hold a full signed product
package conv_mesh_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    function automatic int cnt_width(input int kmax);
        return $clog2(kmax + 1);
    endfunction

    function automatic int row_width(input int rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

endpackage

`define CONV_MESH_CHECK_ACC_W(acc_w, w) \
    if ((acc_w) < 2*(w)) begin : g_acc_w_check \
        $error("conv_mesh: ACC_W must be >= 2*W"); \
    end

// File: rtl/mac_cell.sv
// mac_cell: one signed multiply-accumulate register of the mesh.
//   CLK, RST : clock (rising edge), asynchronous active-high reset
//   load     : load 'bias' into the accumulator (has priority over en)
//   en       : accumulate sext(k*n) this edge
//   bias     : initial accumulator value
//   k, n     : signed kernel and neuron operands
//   acc      : accumulator; wraps modulo 2^ACC_W
module mac_cell
    import conv_mesh_pkg::*;
#(
    parameter int W     = 16,
    parameter int ACC_W = 40
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load,
    input  logic             en,
    input  logic [ACC_W-1:0] bias,
    input  logic [W-1:0]     k,
    input  logic [W-1:0]     n,
    output logic [ACC_W-1:0] acc
);

    logic signed [2*W-1:0]   prod;
    logic signed [ACC_W-1:0] prod_ext;

    always_comb begin
        prod     = $signed(k) * $signed(n);
        prod_ext = ACC_W'(prod);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            acc <= '0;
        end else if (load) begin
            acc <= bias;
        end else if (en) begin
            acc <= acc + prod_ext;
        end
    end

endmodule

// File: rtl/conv_mesh_seq.sv
// conv_mesh_seq: ROWS x COLS signed MAC mesh with its own job sequencer.
//   CLK, RST   : clock (rising edge), asynchronous active-high reset
//   start      : job request, sampled in IDLE together with taps and bias_in
//   taps       : taps per job (clamped to KMAX); 0 drains the biases directly
//   bias_in    : per-row initial accumulator value
//   busy       : job in progress (state != IDLE)
//   in_valid/in_ready : operand beat handshake (ready only in COMPUTE)
//   k_in, n_in : kernel value per row, neuron value per column
//   out_valid/out_ready : result row handshake, one row per handshake
//   out_row, out_data   : row index and its column accumulators (0 when idle)
//   done       : one-cycle pulse after the last row is accepted
module conv_mesh_seq
    import conv_mesh_pkg::*;
#(
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int W     = 16,
    parameter int ACC_W = 40,
    parameter int KMAX  = 49,
    parameter int CNT_W = cnt_width(KMAX),
    parameter int RW    = row_width(ROWS)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    input  logic [CNT_W-1:0]      taps,
    input  logic [ROWS*ACC_W-1:0] bias_in,
    output logic                  busy,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ROWS*W-1:0]     k_in,
    input  logic [COLS*W-1:0]     n_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [RW-1:0]         out_row,
    output logic [COLS*ACC_W-1:0] out_data,
    output logic                  done
);

    `CONV_MESH_CHECK_ACC_W(ACC_W, W)

    state_t           state, state_nx;
    logic [CNT_W-1:0] tap_cnt, taps_q, taps_cl;
    logic [RW-1:0]    row_cnt;
    logic             done_q;
    logic             load, beat, last_beat, hs, last_row;
    logic [ACC_W-1:0] acc [ROWS][COLS];

    always_comb begin
        taps_cl   = (taps > CNT_W'(KMAX)) ? CNT_W'(KMAX) : taps;
        load      = (state == IDLE) && start;
        beat      = (state == COMPUTE) && in_valid;
        last_beat = beat && (tap_cnt == (taps_q - CNT_W'(1)));
        hs        = (state == DRAIN) && out_ready;
        last_row  = hs && (row_cnt == RW'(ROWS - 1));
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = (taps_cl == '0) ? DRAIN : COMPUTE;
            COMPUTE: if (last_beat) state_nx = DRAIN;
            DRAIN:   if (last_row) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        busy      = (state != IDLE);
        in_ready  = (state == COMPUTE);
        out_valid = (state == DRAIN);
        done      = done_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            tap_cnt <= '0;
            taps_q  <= '0;
            row_cnt <= '0;
            done_q  <= 1'b0;
        end else begin
            state  <= state_nx;
            done_q <= last_row;
            if (load) begin
                taps_q  <= taps_cl;
                tap_cnt <= '0;
            end else if (beat) begin
                tap_cnt <= tap_cnt + CNT_W'(1);
            end
            if (last_row) begin
                row_cnt <= '0;
            end else if (hs) begin
                row_cnt <= row_cnt + RW'(1);
            end
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            mac_cell #(
                .W     (W),
                .ACC_W (ACC_W)
            ) u_cell (
                .CLK  (CLK),
                .RST  (RST),
                .load (load),
                .en   (beat),
                .bias (bias_in[ACC_W*(r+1)-1 -: ACC_W]),
                .k    (k_in[W*(r+1)-1 -: W]),
                .n    (n_in[W*(c+1)-1 -: W]),
                .acc  (acc[r][c])
            );
        end
    end

    // Output is forced to zero outside DRAIN so downstream never sees stale rows.
    always_comb begin
        out_row  = '0;
        out_data = '0;
        if (state == DRAIN) begin
            out_row = row_cnt;
            for (int unsigned c = 0; c < COLS; c++) begin
                out_data[ACC_W*c +: ACC_W] = acc[row_cnt][c];
            end
        end
    end

endmodule

// File: tb/tb_conv_mesh_seq.sv
// tb_conv_mesh_seq: scoreboard bench for conv_mesh_seq. Expected rows are
// computed by a reference accumulator model as beats are driven and pushed to
// a queue; the drain pops and compares them against the DUT output.
module tb_conv_mesh_seq;
    import conv_mesh_pkg::*;

    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int W     = 16;
    localparam int ACC_W = 40;
    localparam int KMAX  = 49;
    localparam int CNT_W = cnt_width(KMAX);
    localparam int RW    = row_width(ROWS);

    logic                  CLK, RST, start, busy, in_valid, in_ready;
    logic                  out_valid, out_ready, done;
    logic [CNT_W-1:0]      taps;
    logic [ROWS*ACC_W-1:0] bias_in;
    logic [ROWS*W-1:0]     k_in;
    logic [COLS*W-1:0]     n_in;
    logic [RW-1:0]         out_row;
    logic [COLS*ACC_W-1:0] out_data;

    typedef struct packed {
        logic [RW-1:0]         row;
        logic [COLS*ACC_W-1:0] data;
    } row_t;

    row_t             sb [$];
    logic [ACC_W-1:0] m_acc  [ROWS][COLS];
    logic [ACC_W-1:0] bias_v [ROWS];
    int               tests = 0;
    int               fails = 0;

    conv_mesh_seq #(
        .ROWS  (ROWS),
        .COLS  (COLS),
        .W     (W),
        .ACC_W (ACC_W),
        .KMAX  (KMAX)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .start     (start),
        .taps      (taps),
        .bias_in   (bias_in),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .k_in      (k_in),
        .n_in      (n_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_row   (out_row),
        .out_data  (out_data),
        .done      (done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        check({tag, "_busy"},  256'(busy),      256'(0));
        check({tag, "_ready"}, 256'(in_ready),  256'(0));
        check({tag, "_valid"}, 256'(out_valid), 256'(0));
        check({tag, "_done"},  256'(done),      256'(0));
        check({tag, "_row"},   256'(out_row),   256'(0));
        check({tag, "_data"},  256'(out_data),  256'(0));
    endtask

    // Caller sits 1 time unit after a rising edge; returns at the same phase.
    task automatic start_job(input int t);
        for (int r = 0; r < ROWS; r++) begin
            bias_in[r*ACC_W +: ACC_W] = bias_v[r];
            for (int c = 0; c < COLS; c++) m_acc[r][c] = bias_v[r];
        end
        taps  = CNT_W'(t);
        start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
    endtask

    task automatic drive_beat(input logic rnd, input logic [W-1:0] kv, input logic [W-1:0] nv);
        logic [W-1:0] kr [ROWS];
        logic [W-1:0] nc [COLS];
        for (int r = 0; r < ROWS; r++) begin
            kr[r] = rnd ? W'($urandom) : kv;
            k_in[r*W +: W] = kr[r];
        end
        for (int c = 0; c < COLS; c++) begin
            nc[c] = rnd ? W'($urandom) : nv;
            n_in[c*W +: W] = nc[c];
        end
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                m_acc[r][c] = m_acc[r][c] +
                    ACC_W'(longint'($signed(kr[r])) * longint'($signed(nc[c])));
        in_valid = 1'b1;
    endtask

    task automatic drain(input int hold);
        row_t e;
        out_ready = (hold == 0);
        for (int r = 0; r < ROWS; r++) begin
            if (sb.size() == 0) begin
                check("sb_empty", 256'(1), 256'(0));
                e = '0;
            end else begin
                e = sb.pop_front();
            end
            @(negedge CLK);
            check("out_valid", 256'(out_valid), 256'(1));
            check("busy_drain", 256'(busy), 256'(1));
            check("rdy_drain", 256'(in_ready), 256'(0));
            check("out_row", 256'(out_row), 256'(e.row));
            check("out_data", 256'(out_data), 256'(e.data));
            if (r == 0 && hold > 0) begin
                for (int h = 0; h < hold; h++) begin
                    @(posedge CLK); #1;
                    @(negedge CLK);
                    check("hold_valid", 256'(out_valid), 256'(1));
                    check("hold_row", 256'(out_row), 256'(0));
                    check("hold_data", 256'(out_data), 256'(e.data));
                end
                out_ready = 1'b1;
            end
            @(posedge CLK); #1;
        end
        out_ready = 1'b0;
        @(negedge CLK);
        check("done_pulse", 256'(done), 256'(1));
        check("busy_done", 256'(busy), 256'(0));
        check("valid_idle", 256'(out_valid), 256'(0));
        check("data_idle", 256'(out_data), 256'(0));
        @(posedge CLK); #1;
        @(negedge CLK);
        check("done_once", 256'(done), 256'(0));
        @(posedge CLK); #1;
    endtask

    task automatic run_job(input int t, input logic rnd, input logic [W-1:0] kv,
                           input logic [W-1:0] nv, input logic gaps, input int hold);
        int   tc;
        row_t e;
        tc = (t > KMAX) ? KMAX : t;
        start_job(t);
        for (int b = 0; b < tc; b++) begin
            if (gaps && b > 0) begin
                in_valid = 1'b0;
                @(negedge CLK);
                check("gap_ready", 256'(in_ready), 256'(1));
                @(posedge CLK); #1;
            end
            drive_beat(rnd, kv, nv);
            @(negedge CLK);
            check("beat_ready", 256'(in_ready), 256'(1));
            @(posedge CLK); #1;
        end
        in_valid = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            e.row = RW'(r);
            for (int c = 0; c < COLS; c++) e.data[c*ACC_W +: ACC_W] = m_acc[r][c];
            sb.push_back(e);
        end
        drain(hold);
    endtask

    initial begin
        RST = 1'b1; start = 1'b0; taps = '0; bias_in = '0;
        in_valid = 1'b0; k_in = '0; n_in = '0; out_ready = 1'b0;
        #2 chk_idle("rst0");
        #10 RST = 1'b0;
        @(posedge CLK); #1;

        // bias 0, three beats of 2*3 -> 18 everywhere
        for (int r = 0; r < ROWS; r++) bias_v[r] = '0;
        run_job(3, 1'b0, 16'd2, 16'd3, 1'b0, 0);

        // signed product: 5 + (-1 * 32767)
        for (int r = 0; r < ROWS; r++) bias_v[r] = ACC_W'(5);
        run_job(1, 1'b0, 16'hFFFF, 16'h7FFF, 1'b0, 0);

        // taps = 0 passes the biases straight to the drain
        for (int r = 0; r < ROWS; r++) bias_v[r] = ACC_W'(r + 10);
        run_job(0, 1'b0, 16'd0, 16'd0, 1'b0, 0);

        // operand gaps and output backpressure, random operands, negative bias
        for (int r = 0; r < ROWS; r++) bias_v[r] = ACC_W'(-100 * (r + 1));
        run_job(4, 1'b1, 16'd0, 16'd0, 1'b1, 5);

        // tap count above KMAX clamps to KMAX
        for (int r = 0; r < ROWS; r++) bias_v[r] = ACC_W'($urandom);
        run_job(55, 1'b1, 16'd0, 16'd0, 1'b0, 0);

        // reset asserted mid-cycle during DRAIN
        for (int r = 0; r < ROWS; r++) bias_v[r] = ACC_W'(r + 1);
        start_job(0);
        @(negedge CLK);
        check("pre_rst_valid", 256'(out_valid), 256'(1));
        #2 RST = 1'b1;
        #1 chk_idle("rst_drain");
        #3 RST = 1'b0;
        @(posedge CLK); #1;

        // reset mid-COMPUTE after 2 of 4 beats, then a clean job
        for (int r = 0; r < ROWS; r++) bias_v[r] = ACC_W'(1000);
        start_job(4);
        for (int b = 0; b < 2; b++) begin
            drive_beat(1'b1, 16'd0, 16'd0);
            @(posedge CLK); #1;
        end
        in_valid = 1'b0;
        #3 RST = 1'b1;
        #1 chk_idle("rst_comp");
        #2 RST = 1'b0;
        @(posedge CLK); #1;
        for (int r = 0; r < ROWS; r++) bias_v[r] = ACC_W'(7);
        run_job(1, 1'b0, 16'd1, 16'd1, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
